mm_final_sub: RTL

MM_FINAL_SUB -- requirements
Module: mm_final_sub

---
 rtl/mm_final_sub_pkg.sv | 21 ++
 rtl/mm_final_sub_mlclaa.sv | 82 ++++++++
 rtl/mm_final_sub.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mm_final_sub_pkg.sv
// ----------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the Montgomery final-subtraction block.
//   state_t     : FSM state encoding (LOAD -> DECIDE -> OUT -> LOAD)
//   DEFAULT_K   : default word width in bits (multiple of 16)
//   DEFAULT_N   : default number of words per operand
//   STAT_W      : width of the optional subtraction statistics counter
// ----------------------------------------------------------------------------
package mm_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DECIDE = 2'd1,
        OUT    = 2'd2
    } state_t;

    localparam int DEFAULT_K = 128;
    localparam int DEFAULT_N = 32;
    localparam int STAT_W    = 16;

endpackage

// File: rtl/mm_final_sub_mlclaa.sv
// ----------------------------------------------------------------------------
// simple_mlclaa_x16bit
// Multi-level carry-lookahead adder built from 16-bit slices. Each slice is
// split into four 4-bit groups; group generate/propagate terms are combined
// by a second lookahead level, and the slices are chained by their carry.
// Ports:
//   a   : first addend, W bits
//   bin : second addend, W bits (already inverted by the caller for subtract)
//   ci  : carry in
//   s   : sum, W bits
//   co  : carry out of the top bit
// W must be a multiple of 16.
// ----------------------------------------------------------------------------
module simple_mlclaa_x16bit #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] bin,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    localparam int NB = W / 16;

    logic [W-1:0] w_gen;
    logic [W-1:0] w_prop;

    assign w_gen  = a & bin;
    assign w_prop = a ^ bin;

    always_comb begin : claTree
        logic [W:0] carry;
        logic [3:0] grpG;
        logic [3:0] grpP;
        logic [4:0] grpC;
        logic       gAcc;
        logic       pAcc;

        carry    = '0;
        carry[0] = ci;
        grpG     = '0;
        grpP     = '0;
        grpC     = '0;
        gAcc     = 1'b0;
        pAcc     = 1'b1;

        for (int b = 0; b < NB; b++) begin
            // first level: generate/propagate of each 4-bit group
            for (int g = 0; g < 4; g++) begin
                gAcc = 1'b0;
                pAcc = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    gAcc = w_gen[b*16 + g*4 + k] | (w_prop[b*16 + g*4 + k] & gAcc);
                    pAcc = pAcc & w_prop[b*16 + g*4 + k];
                end
                grpG[g] = gAcc;
                grpP[g] = pAcc;
            end

            // second level: carries into each group of the slice
            grpC[0] = carry[b*16];
            for (int g = 0; g < 4; g++) begin
                grpC[g+1] = grpG[g] | (grpP[g] & grpC[g]);
            end

            // bit carries inside each group start from the lookahead carry
            for (int g = 0; g < 4; g++) begin
                carry[b*16 + g*4] = grpC[g];
                for (int k = 0; k < 4; k++) begin
                    carry[b*16 + g*4 + k + 1] = w_gen[b*16 + g*4 + k]
                                              | (w_prop[b*16 + g*4 + k] & carry[b*16 + g*4 + k]);
                end
            end
            carry[(b+1)*16] = grpC[4];
        end

        s  = w_prop ^ carry[W-1:0];
        co = carry[W];
    end

endmodule

// File: rtl/mm_final_sub.sv
// ----------------------------------------------------------------------------
// mm_final_sub
// Final conditional subtraction of a Montgomery multiplier:
//     R = (S >= M) ? S - M : S      (precondition S < 2M)
// S (N*K bits plus top bit s_hi) and M arrive one word per beat, LS word
// first. While loading, S and D = S - M are both buffered word by word; after
// the last word a single DECIDE cycle picks which buffer to stream out.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid / s_ready : input handshake
//   s_data, m_data    : word i of S and of M
//   s_hi              : bit N*K of S, sampled with word N-1 only
//   o_valid / o_ready : output handshake
//   o_data, o_last    : word j of R, o_last marks word N-1
//   sub_cnt           : (only with MM_FINAL_SUB_STAT_EN) count of results
//                       where the subtraction was taken, saturating
// Configuration macro: MM_FINAL_SUB_STAT_EN
// ----------------------------------------------------------------------------
module mm_final_sub
    import mm_pkg::*;
#(
    parameter int K = DEFAULT_K,
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [K-1:0] s_data,
    input  logic [K-1:0] m_data,
    input  logic         s_hi,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [K-1:0] o_data,
    output logic         o_last
`ifdef MM_FINAL_SUB_STAT_EN
    ,
    output logic [STAT_W-1:0] sub_cnt
`endif
);

    localparam int            CW          = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX    = CW'(N - 1);
    localparam logic          SINGLE_WORD = (N == 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic          r_sel;
    logic          r_sHi;
    logic          r_sReady;
    logic          r_oValid;
    logic          r_oLast;
    logic [K-1:0]  r_oData;

    logic [K-1:0]  r_sBuf [N];
    logic [K-1:0]  r_dBuf [N];

    logic [K-1:0]  w_sum;
    logic          w_co;
    logic          w_accept;
    logic          w_sel;
    logic [CW-1:0] w_nextIdx;
    logic [K-1:0]  w_mInv;

    assign w_mInv    = ~m_data;
    assign w_accept  = s_valid & r_sReady;
    // S >= M exactly when S - M does not borrow, or S has its top bit set
    assign w_sel     = r_sHi | r_carry;
    assign w_nextIdx = r_cnt + CW'(1);

    simple_mlclaa_x16bit #(
        .W (K)
    ) u_add (
        .a   (s_data),
        .bin (w_mInv),
        .ci  (r_carry),
        .s   (w_sum),
        .co  (w_co)
    );

    // Operand buffers carry no reset: a partial transfer is simply discarded.
    always_ff @(posedge clk) begin
        if (r_state == LOAD && w_accept) begin
            r_sBuf[r_cnt] <= s_data;
            r_dBuf[r_cnt] <= w_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= LOAD;
            r_cnt    <= '0;
            r_carry  <= 1'b1;
            r_sel    <= 1'b0;
            r_sHi    <= 1'b0;
            r_sReady <= 1'b1;
            r_oValid <= 1'b0;
            r_oLast  <= 1'b0;
            r_oData  <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_carry <= w_co;
                        if (r_cnt == LAST_IDX) begin
                            r_sHi    <= s_hi;
                            r_cnt    <= '0;
                            r_sReady <= 1'b0;
                            r_state  <= DECIDE;
                        end else begin
                            r_cnt <= w_nextIdx;
                        end
                    end
                end

                DECIDE: begin
                    r_sel    <= w_sel;
                    r_oData  <= w_sel ? r_dBuf[0] : r_sBuf[0];
                    r_oValid <= 1'b1;
                    r_oLast  <= SINGLE_WORD;
                    r_state  <= OUT;
                end

                OUT: begin
                    if (o_ready) begin
                        if (r_cnt == LAST_IDX) begin
                            r_cnt    <= '0;
                            r_carry  <= 1'b1;
                            r_oValid <= 1'b0;
                            r_oLast  <= 1'b0;
                            r_sReady <= 1'b1;
                            r_state  <= LOAD;
                        end else begin
                            r_cnt   <= w_nextIdx;
                            r_oData <= r_sel ? r_dBuf[w_nextIdx] : r_sBuf[w_nextIdx];
                            r_oLast <= (w_nextIdx == LAST_IDX);
                        end
                    end
                end

                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign s_ready = r_sReady;
    assign o_valid = r_oValid;
    assign o_data  = r_oData;
    assign o_last  = r_oLast;

`ifdef MM_FINAL_SUB_STAT_EN
    logic [STAT_W-1:0] r_subCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_subCnt <= '0;
        end else if (r_state == DECIDE && w_sel && (r_subCnt != {STAT_W{1'b1}})) begin
            r_subCnt <= r_subCnt + STAT_W'(1);
        end
    end

    assign sub_cnt = r_subCnt;
`endif

endmodule
